regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Sequencing controller and two-port arbiter for the CPU core's general-purpose register file. It shares the single register file between requester A (execute stage) and requester B (debug/loader port) using a req/ack handshake and round-robin arbitration. It converts each granted transaction (read pair, write, clear) into correctly timed `get_enable` / `set_enable` / `reset_enable` pulses, and returns registered read data to the requester.

## Interface
- `WORD_SIZE`, default 8 (from parameters.vh): register data width.
- `REG_ADDR_SIZE`, default 3 (from parameters.vh): register address width.
- `REG_NUM`, default 8 (from parameters.vh): register count; used only for address range documentation.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `a_req` / `b_req`  in  1  request, held until the matching ack.
- `a_op` / `b_op`  in  2  operation: 00 read, 01 write, 10 clear, 11 no-op.
- `a_addr1`, `a_addr2` / `b_addr1`, `b_addr2`  in  REG_ADDR_SIZE  read addresses; addr1 is also the write address.
- `a_wdata` / `b_wdata`  in  WORD_SIZE  write data.
- `a_ack` / `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata1`, `a_rdata2` / `b_rdata1`, `b_rdata2`  out  WORD_SIZE  read results, held until the next read by the same requester completes.
- `busy`  out  1  high whenever the state is not IDLE.
- `rf_num1`, `rf_num2`  out  REG_ADDR_SIZE  register file addresses.
- `rf_set_val`  out  WORD_SIZE  register file write data.
- `rf_get_enable`, `rf_set_enable`, `rf_reset_enable`  out  1  register file strobes.
- `rf_out1`, `rf_out2`  in  WORD_SIZE  register file read data, registered inside the register file.

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → ACK → IDLE. Every transition is unconditional except the one leaving IDLE.
- IDLE: if any request is high, grant one requester.
  - Latch its op, addr1, addr2 and wdata into `rf_num1`, `rf_num2`, `rf_set_val` and an internal op register.
  - Record the grant and go to ISSUE.
  - If no request is high, stay in IDLE.
- Arbitration is round-robin with a last-grant pointer, reset to B so that A wins the first contention.
  - Sole requester: granted.
  - Both requesting: the requester not granted last wins.
  - The pointer updates on every grant.
- ISSUE: assert exactly one strobe for one cycle: read → `rf_get_enable`, write → `rf_set_enable`, clear → `rf_reset_enable`, no-op → none. Two strobes are never high together.
- CAPTURE: for a read, load `rf_out1` / `rf_out2` into the granted requester's rdata registers at the end of the cycle.
- ACK: pulse the granted requester's ack for one cycle, then return to IDLE.
- Requester rules:
  - Hold req and all fields stable from assertion until the cycle ack is high.
  - To end, drop req in the cycle after ack.
  - Leaving req high in the cycle after ack issues a new transaction with the fields present at that point.
- `rf_num*` and `rf_set_val` hold their latched values from ISSUE through ACK and keep them in IDLE until the next grant.
- The non-granted requester's rdata and ack are untouched.

## Timing
- Edge E0: IDLE samples req. E1: register file acts on the strobe. E2: rdata captured. E3: ack falls.
- Ack is high during the cycle between E2 and E3: 3 cycles from sampled req to ack, 4 cycles per transaction, no pipelining.
- Read data is valid at the requester in the same cycle ack is high.
- Writes and clears are visible to any read granted after their ack.
- Reset (`reset_n` low, any state, asynchronous):
  - FSM goes to IDLE.
  - All strobes, acks and `busy` go to 0.
  - `rf_num*`, `rf_set_val` and all rdata go to 0.
  - The pointer goes to B.
- An in-flight transaction is abandoned with no ack. A strobe cut by reset before E1 has no effect. The requester must reissue.
- The block does not clear the register file on reset. Software issues a clear op.

## Structure
- A shared include alongside parameters.vh holds:
  - op codes `OP_READ`=2'b00, `OP_WRITE`=2'b01, `OP_CLEAR`=2'b10, `OP_NOP`=2'b11;
  - FSM state encodings S_IDLE, S_ISSUE, S_CAPTURE, S_ACK.
- One sub-module, `rr_arbiter2`:
  - inputs: two requests, an update enable;
  - outputs: one-hot grant;
  - holds the last-grant pointer internally.
- The top level holds the FSM, the latches and the output muxing.

## Test plan
- Reset: hold `reset_n` low 2 cycles with both reqs high → all outputs 0, `busy`=0, no strobe. Release → A granted first.
- A writes 0x5A to r3, then A reads r3/r0 → `rf_set_enable` high only in ISSUE with `rf_num1`=3. Read returns `a_rdata1`=0x5A, `a_rdata2`=0x00, ack 3 edges after the req sample.
- A and B both request continuously (A writes 0x11 to r1, B reads r1/r1):
  - grants alternate A, B, A, B;
  - B's first read returns 0x11 on both outputs;
  - `a_rdata*` stays unchanged during B transactions.
- B clear after writing 0xFF to r7 → only `rf_reset_enable` pulses. A subsequent read of r7/r2 returns 0x00/0x00.
- Reset asserted during ISSUE of an A write of 0x33 to r5 → no `a_ack`, strobes 0 immediately. A later read of r5 returns the prior value.
- B op 11 → `b_ack` after 3 cycles, no strobe asserted, all registers unchanged.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: default sizes, op codes and
// the sequencing FSM state encoding.
package regfile_arbiter_pkg;

  localparam int DEF_WORD_SIZE     = 8;
  localparam int DEF_REG_ADDR_SIZE = 3;
  // Register count; the address width above must cover it.
  localparam int DEF_REG_NUM       = 8;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a last-grant
// pointer that moves only when the caller accepts a grant.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_b_q;
  logic last_b_d;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      grant = last_b_q ? 2'b01 : 2'b10;
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (update && (grant != 2'b00)) begin
      last_b_d = grant[1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register file between requester A and B; each granted transaction
// runs IDLE -> ISSUE -> CAPTURE -> ACK with a single strobe in ISSUE.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     a_req,
  input  logic [1:0]               a_op,
  input  logic [REG_ADDR_SIZE-1:0] a_addr1,
  input  logic [REG_ADDR_SIZE-1:0] a_addr2,
  input  logic [WORD_SIZE-1:0]     a_wdata,
  output logic                     a_ack,
  output logic [WORD_SIZE-1:0]     a_rdata1,
  output logic [WORD_SIZE-1:0]     a_rdata2,
  input  logic                     b_req,
  input  logic [1:0]               b_op,
  input  logic [REG_ADDR_SIZE-1:0] b_addr1,
  input  logic [REG_ADDR_SIZE-1:0] b_addr2,
  input  logic [WORD_SIZE-1:0]     b_wdata,
  output logic                     b_ack,
  output logic [WORD_SIZE-1:0]     b_rdata1,
  output logic [WORD_SIZE-1:0]     b_rdata2,
  output logic                     busy,
  output logic [REG_ADDR_SIZE-1:0] rf_num1,
  output logic [REG_ADDR_SIZE-1:0] rf_num2,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  state_e                   state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic                     gnt_b_q, gnt_b_d;
  logic [REG_ADDR_SIZE-1:0] num1_q, num1_d, num2_q, num2_d;
  logic [WORD_SIZE-1:0]     set_val_q, set_val_d;
  logic [WORD_SIZE-1:0]     a_rdata1_q, a_rdata1_d, a_rdata2_q, a_rdata2_d;
  logic [WORD_SIZE-1:0]     b_rdata1_q, b_rdata1_d, b_rdata2_q, b_rdata2_d;
  logic [1:0]               grant;
  logic                     arb_update;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req_a   (a_req),
    .req_b   (b_req),
    .update  (arb_update),
    .grant   (grant)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    gnt_b_d    = gnt_b_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    set_val_d  = set_val_q;
    a_rdata1_d = a_rdata1_q;
    a_rdata2_d = a_rdata2_q;
    b_rdata1_d = b_rdata1_q;
    b_rdata2_d = b_rdata2_q;
    arb_update = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          arb_update = 1'b1;
          gnt_b_d    = grant[1];
          state_d    = S_ISSUE;
          if (grant[1]) begin
            op_d      = b_op;
            num1_d    = b_addr1;
            num2_d    = b_addr2;
            set_val_d = b_wdata;
          end else begin
            op_d      = a_op;
            num1_d    = a_addr1;
            num2_d    = a_addr2;
            set_val_d = a_wdata;
          end
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // The register file output is valid here, one cycle after the get strobe.
        if (op_q == OP_READ) begin
          if (gnt_b_q) begin
            b_rdata1_d = rf_out1;
            b_rdata2_d = rf_out2;
          end else begin
            a_rdata1_d = rf_out1;
            a_rdata2_d = rf_out2;
          end
        end
        state_d = S_ACK;
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      gnt_b_q    <= 1'b0;
      num1_q     <= '0;
      num2_q     <= '0;
      set_val_q  <= '0;
      a_rdata1_q <= '0;
      a_rdata2_q <= '0;
      b_rdata1_q <= '0;
      b_rdata2_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      gnt_b_q    <= gnt_b_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      set_val_q  <= set_val_d;
      a_rdata1_q <= a_rdata1_d;
      a_rdata2_q <= a_rdata2_d;
      b_rdata1_q <= b_rdata1_d;
      b_rdata2_q <= b_rdata2_d;
    end
  end

  // Strobes decode straight from flops so an asynchronous reset kills them at once.
  assign rf_get_enable   = (state_q == S_ISSUE) && (op_q == OP_READ);
  assign rf_set_enable   = (state_q == S_ISSUE) && (op_q == OP_WRITE);
  assign rf_reset_enable = (state_q == S_ISSUE) && (op_q == OP_CLEAR);
  assign a_ack           = (state_q == S_ACK) && !gnt_b_q;
  assign b_ack           = (state_q == S_ACK) && gnt_b_q;
  assign busy            = (state_q != S_IDLE);
  assign rf_num1         = num1_q;
  assign rf_num2         = num2_q;
  assign rf_set_val      = set_val_q;
  assign a_rdata1        = a_rdata1_q;
  assign a_rdata2        = a_rdata2_q;
  assign b_rdata1        = b_rdata1_q;
  assign b_rdata2        = b_rdata2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file attached.
module tb_regfile_arbiter;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_NP  = 2'b11;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_op = OP_NP, b_op = OP_NP;
  logic [2:0] a_addr1 = '0, a_addr2 = '0, b_addr1 = '0, b_addr2 = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, busy;
  logic [7:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic [2:0] rf_num1, rf_num2;
  logic [7:0] rf_set_val;
  logic       rf_get_enable, rf_set_enable, rf_reset_enable;
  logic [7:0] rf_out1 = '0, rf_out2 = '0;

  int n_compared = 0;
  int n_mismatched = 0;

  regfile_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_op(a_op), .a_addr1(a_addr1), .a_addr2(a_addr2), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata1(a_rdata1), .a_rdata2(a_rdata2),
    .b_req(b_req), .b_op(b_op), .b_addr1(b_addr1), .b_addr2(b_addr2), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2),
    .busy(busy), .rf_num1(rf_num1), .rf_num2(rf_num2), .rf_set_val(rf_set_val),
    .rf_get_enable(rf_get_enable), .rf_set_enable(rf_set_enable),
    .rf_reset_enable(rf_reset_enable), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clock = ~clock;

  // Behavioural register file: registered reads, not affected by the arbiter reset.
  logic [7:0] regs [8] = '{default: 8'h00};
  always @(posedge clock) begin
    if (rf_reset_enable) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (rf_set_enable) begin
      regs[rf_num1] <= rf_set_val;
    end
    if (rf_get_enable) begin
      rf_out1 <= regs[rf_num1];
      rf_out2 <= regs[rf_num2];
    end
  end

  // Strobe and ack monitor sampled on the falling edge.
  int n_get = 0, n_set = 0, n_rst = 0, n_multi = 0, n_a_ack = 0;
  logic [2:0] last_set_num1 = '0;
  logic [7:0] last_set_val = '0;
  always @(negedge clock) begin
    if (rf_get_enable) n_get++;
    if (rf_set_enable) begin
      n_set++;
      last_set_num1 = rf_num1;
      last_set_val = rf_set_val;
    end
    if (rf_reset_enable) n_rst++;
    if ((int'(rf_get_enable) + int'(rf_set_enable) + int'(rf_reset_enable)) > 1) n_multi++;
    if (a_ack) n_a_ack++;
  end

  task automatic run_txn(input bit use_b, input logic [1:0] op, input logic [2:0] ad1,
                         input logic [2:0] ad2, input logic [7:0] wd,
                         output int cycles, output bit acked);
    @(negedge clock);
    if (use_b) begin
      b_op = op; b_addr1 = ad1; b_addr2 = ad2; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_op = op; a_addr1 = ad1; a_addr2 = ad2; a_wdata = wd; a_req = 1'b1;
    end
    cycles = 0;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clock);
      cycles++;
      if (use_b ? b_ack : a_ack) acked = 1'b1;
    end
    if (use_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    a_req = 1'b1; b_req = 1'b1; a_op = OP_NP; b_op = OP_NP;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_compared++;
    if ({a_ack, b_ack, busy, rf_get_enable, rf_set_enable, rf_reset_enable} !== 6'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000",
               {a_ack, b_ack, busy, rf_get_enable, rf_set_enable, rf_reset_enable});
    end
    n_compared++;
    if ({rf_num1, rf_num2, rf_set_val, a_rdata1, a_rdata2, b_rdata1, b_rdata2} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h required 0",
               {rf_num1, rf_num2, rf_set_val, a_rdata1, a_rdata2, b_rdata1, b_rdata2});
    end
    reset_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (a_ack || b_ack) got = 1'b1;
    end
    n_compared++;
    if (!(got && a_ack && !b_ack)) begin
      n_mismatched++;
      $display("[TB] FAIL first_grant: got a_ack=%b b_ack=%b required a_ack=1 b_ack=0", a_ack, b_ack);
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write_read();
    int cyc, s_get, s_set, s_rst;
    bit ok;
    s_get = n_get; s_set = n_set; s_rst = n_rst;
    run_txn(1'b0, OP_WR, 3'd3, 3'd0, 8'h5A, cyc, ok);
    n_compared++;
    if (!ok || (n_set - s_set) != 1 || (n_get - s_get) != 0 || (n_rst - s_rst) != 0) begin
      n_mismatched++;
      $display("[TB] FAIL write_strobes: got ack=%b set=%0d get=%0d rst=%0d required 1/1/0/0",
               ok, n_set - s_set, n_get - s_get, n_rst - s_rst);
    end
    n_compared++;
    if (last_set_num1 !== 3'd3 || last_set_val !== 8'h5A) begin
      n_mismatched++;
      $display("[TB] FAIL write_fields: got num1=%0d val=%h required 3/5a", last_set_num1, last_set_val);
    end
    s_get = n_get;
    run_txn(1'b0, OP_RD, 3'd3, 3'd0, 8'h00, cyc, ok);
    n_compared++;
    if (!ok || cyc != 3 || (n_get - s_get) != 1) begin
      n_mismatched++;
      $display("[TB] FAIL read_latency: got ack=%b cycles=%0d gets=%0d required 1/3/1", ok, cyc, n_get - s_get);
    end
    n_compared++;
    if (a_rdata1 !== 8'h5A || a_rdata2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL read_data: got %h/%h required 5a/00", a_rdata1, a_rdata2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] order;
    int k;
    bit bad_b, bad_a;
    order = '0; k = 0; bad_b = 1'b0; bad_a = 1'b0;
    @(negedge clock);
    a_op = OP_WR; a_addr1 = 3'd1; a_addr2 = 3'd0; a_wdata = 8'h11; a_req = 1'b1;
    @(negedge clock);
    b_op = OP_RD; b_addr1 = 3'd1; b_addr2 = 3'd1; b_req = 1'b1;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clock);
      if (a_rdata1 !== 8'h5A || a_rdata2 !== 8'h00) bad_a = 1'b1;
      if (a_ack || b_ack) begin
        order[k] = b_ack;
        if (b_ack && (b_rdata1 !== 8'h11 || b_rdata2 !== 8'h11)) bad_b = 1'b1;
        k++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    n_compared++;
    if (k != 4 || order !== 4'b1010) begin
      n_mismatched++;
      $display("[TB] FAIL grant_order: got %0d acks order=%b required 4 acks order=1010", k, order);
    end
    n_compared++;
    if (bad_b) begin
      n_mismatched++;
      $display("[TB] FAIL b_read_after_a_write: got %h/%h required 11/11", b_rdata1, b_rdata2);
    end
    n_compared++;
    if (bad_a) begin
      n_mismatched++;
      $display("[TB] FAIL a_rdata_hold: got %h/%h required 5a/00", a_rdata1, a_rdata2);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_clear();
    int cyc, s_get, s_set, s_rst;
    bit ok;
    run_txn(1'b1, OP_WR, 3'd7, 3'd0, 8'hFF, cyc, ok);
    s_get = n_get; s_set = n_set; s_rst = n_rst;
    run_txn(1'b1, OP_CLR, 3'd0, 3'd0, 8'h00, cyc, ok);
    n_compared++;
    if (!ok || (n_rst - s_rst) != 1 || (n_set - s_set) != 0 || (n_get - s_get) != 0) begin
      n_mismatched++;
      $display("[TB] FAIL clear_strobes: got ack=%b rst=%0d set=%0d get=%0d required 1/1/0/0",
               ok, n_rst - s_rst, n_set - s_set, n_get - s_get);
    end
    run_txn(1'b0, OP_RD, 3'd7, 3'd2, 8'h00, cyc, ok);
    n_compared++;
    if (!ok || a_rdata1 !== 8'h00 || a_rdata2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL read_after_clear: got ack=%b %h/%h required 1 00/00", ok, a_rdata1, a_rdata2);
    end
  endtask

  task automatic test_reset_midflight();
    int cyc, s_ack;
    bit ok;
    run_txn(1'b0, OP_WR, 3'd5, 3'd0, 8'h77, cyc, ok);
    @(negedge clock);
    a_op = OP_WR; a_addr1 = 3'd5; a_wdata = 8'h33; a_req = 1'b1;
    s_ack = n_a_ack;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_compared++;
    if ({rf_get_enable, rf_set_enable, rf_reset_enable, busy} !== 4'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_strobes: got %b required 0000",
               {rf_get_enable, rf_set_enable, rf_reset_enable, busy});
    end
    a_req = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    n_compared++;
    if ((n_a_ack - s_ack) != 0 || a_rdata1 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_ack: got acks=%0d rdata1=%h required 0/00", n_a_ack - s_ack, a_rdata1);
    end
    run_txn(1'b0, OP_RD, 3'd5, 3'd0, 8'h00, cyc, ok);
    n_compared++;
    if (!ok || a_rdata1 !== 8'h77) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_prior_value: got ack=%b %h required 1 77", ok, a_rdata1);
    end
  endtask

  task automatic test_nop();
    int cyc, s_get, s_set, s_rst;
    bit ok;
    run_txn(1'b1, OP_RD, 3'd5, 3'd5, 8'h00, cyc, ok);
    s_get = n_get; s_set = n_set; s_rst = n_rst;
    run_txn(1'b1, OP_NP, 3'd5, 3'd7, 8'hEE, cyc, ok);
    n_compared++;
    if (!ok || cyc != 3 || (n_get - s_get) != 0 || (n_set - s_set) != 0 || (n_rst - s_rst) != 0) begin
      n_mismatched++;
      $display("[TB] FAIL nop_timing: got ack=%b cycles=%0d strobes=%0d required 1/3/0",
               ok, cyc, (n_get - s_get) + (n_set - s_set) + (n_rst - s_rst));
    end
    n_compared++;
    if (b_rdata1 !== 8'h77 || b_rdata2 !== 8'h77) begin
      n_mismatched++;
      $display("[TB] FAIL nop_rdata_hold: got %h/%h required 77/77", b_rdata1, b_rdata2);
    end
    run_txn(1'b0, OP_RD, 3'd5, 3'd7, 8'h00, cyc, ok);
    n_compared++;
    if (!ok || a_rdata1 !== 8'h77 || a_rdata2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL nop_regs_unchanged: got %h/%h required 77/00", a_rdata1, a_rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_reset_midflight();
    test_nop();
    n_compared++;
    if (n_multi != 0) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_exclusive: got %0d overlaps required 0", n_multi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
